// File: rtl/instr_register_pkg.sv
// Shared opcode encoding and default widths for the instruction register with built-in ALU.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int NUM_REGS_DEFAULT = 32;
  localparam int OP_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/instr_alu.sv
// Combinational execute stage: signed operands are widened to 2*OP_WIDTH before the operation.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEFAULT,
  localparam int RES_WIDTH = 2 * OP_WIDTH
) (
  input  opcode_t                       opc,
  input  logic signed [OP_WIDTH-1:0]    a,
  input  logic signed [OP_WIDTH-1:0]    b,
  output logic signed [RES_WIDTH-1:0]   rez,
  output logic                          err
);

  logic signed [RES_WIDTH-1:0] a_x;
  logic signed [RES_WIDTH-1:0] b_x;

  assign a_x = {{OP_WIDTH{a[OP_WIDTH-1]}}, a};
  assign b_x = {{OP_WIDTH{b[OP_WIDTH-1]}}, b};

  // Widened operands make MULT full-precision and keep DIV free of overflow.
  always_comb begin
    rez = '0;
    err = 1'b0;
    case (opc)
      ZERO:  rez = '0;
      PASSA: rez = a_x;
      PASSB: rez = b_x;
      ADD:   rez = a_x + b_x;
      SUB:   rez = a_x - b_x;
      MULT:  rez = a_x * b_x;
      DIV: begin
        if (b_x == '0) err = 1'b1;
        else           rez = a_x / b_x;
      end
      MOD: begin
        if (b_x == '0) err = 1'b1;
        else           rez = a_x % b_x;
      end
      default: rez = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction store with capture/execute write pipeline, per-entry valid bits and a
// registered write-first read port.
module instr_register_alu
  import instr_register_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int OP_WIDTH = OP_WIDTH_DEFAULT,
  localparam int PTR_WIDTH   = $clog2(NUM_REGS),
  localparam int RES_WIDTH   = 2 * OP_WIDTH,
  localparam int ENTRY_WIDTH = $bits(opcode_t) + 2 * OP_WIDTH + RES_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_en,
  input  logic [PTR_WIDTH-1:0]         write_pointer,
  input  opcode_t                      opcode,
  input  logic signed [OP_WIDTH-1:0]   operand_a,
  input  logic signed [OP_WIDTH-1:0]   operand_b,
  input  logic [PTR_WIDTH-1:0]         read_pointer,
  output logic [ENTRY_WIDTH-1:0]       instruction_word,
  output logic                         pipe_busy,
  output logic [PTR_WIDTH:0]           valid_count
);

  typedef struct packed {
    opcode_t                      opc;
    logic signed [OP_WIDTH-1:0]   op_a;
    logic signed [OP_WIDTH-1:0]   op_b;
    logic signed [RES_WIDTH-1:0]  rez;
    logic                         err;
    logic                         valid;
  } instr_entry_t;

  localparam logic [PTR_WIDTH:0] REGS_LIMIT = (PTR_WIDTH + 1)'(NUM_REGS);

  logic                         s1_valid_q;
  logic [PTR_WIDTH-1:0]         s1_ptr_q;
  opcode_t                      s1_opc_q;
  logic signed [OP_WIDTH-1:0]   s1_a_q;
  logic signed [OP_WIDTH-1:0]   s1_b_q;

  instr_entry_t                 mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]          valid_q, valid_d;
  logic [PTR_WIDTH:0]           count_q, count_d;
  instr_entry_t                 rd_q, rd_d;

  logic signed [RES_WIDTH-1:0]  alu_rez;
  logic                         alu_err;
  instr_entry_t                 commit_entry;
  logic                         commit_en;
  logic                         rd_in_range;

  instr_alu #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .opc (s1_opc_q),
    .a   (s1_a_q),
    .b   (s1_b_q),
    .rez (alu_rez),
    .err (alu_err)
  );

  assign commit_entry = '{opc: s1_opc_q, op_a: s1_a_q, op_b: s1_b_q,
                          rez: alu_rez, err: alu_err, valid: 1'b1};
  assign commit_en    = s1_valid_q && ({1'b0, s1_ptr_q} < REGS_LIMIT);
  assign rd_in_range  = {1'b0, read_pointer} < REGS_LIMIT;

  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    if (commit_en) begin
      valid_d[s1_ptr_q] = 1'b1;
      if (!valid_q[s1_ptr_q]) count_d = count_q + (PTR_WIDTH + 1)'(1);
    end
  end

  // Same-edge commit to the read address wins over the stored copy.
  always_comb begin
    rd_d = '0;
    if (rd_in_range) begin
      if (commit_en && (read_pointer == s1_ptr_q)) rd_d = commit_entry;
      else if (valid_q[read_pointer])              rd_d = mem_q[read_pointer];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      valid_q    <= '0;
      count_q    <= '0;
      rd_q       <= '0;
    end else begin
      s1_valid_q <= load_en;
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_en) begin
      s1_ptr_q <= write_pointer;
      s1_opc_q <= opcode;
      s1_a_q   <= operand_a;
      s1_b_q   <= operand_b;
    end
  end

  // Array data is never reset; the valid bits mask stale contents.
  always_ff @(posedge clk) begin
    if (reset_n && commit_en) mem_q[s1_ptr_q] <= commit_entry;
  end

  assign instruction_word = rd_q;
  assign pipe_busy        = s1_valid_q;
  assign valid_count      = count_q;

endmodule
